// File: rtl/spi_byte_master_if.sv
// System-side handshake bundle for spi_byte_master.
// The master modport is the byte producer/consumer; the slave modport is the SPI engine.
interface spi_byte_master_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data, tx_valid, tx_last,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid, tx_last,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_byte_master.sv
// spi_byte_master: transaction-level SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One byte per valid/ready accept; cs framing with a lead, trail and gap of CLK_DIV
// cycles each. Optional feature macro: SPI_BURST_EN -- a byte accepted with
// tx_last=0 parks in WAIT with cs held low until the next byte is accepted.
// DATA_W must be at least 2; CLK_DIV must be in 2..255 (8-bit divider).
module spi_byte_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_byte_master_if.slave sys,
  output logic             ssck,
  output logic             mosi,
  input  logic             miso,
  output logic             cs
);

  // Edge counter covers the 2*DATA_W-1 ssck edges generated inside SHIFT.
  localparam int              EW          = $clog2(2 * DATA_W);
  localparam logic [7:0]      DIV_RELOAD  = 8'(CLK_DIV - 1);
  localparam logic [EW-1:0]   SHIFT_EDGES = EW'(2 * DATA_W - 1);
  localparam logic [EW-1:0]   LAST_EDGE   = EW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4,
    WAIT  = 3'd5
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [7:0]          div_cnt_reg;
  logic [EW-1:0]       edges_left_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   rx_data_reg;
  logic                rx_valid_reg;
  logic                ssck_reg;
  logic                mosi_reg;
  logic                cs_reg;
  logic                tx_ready;
  logic                busy;
  logic                tick;
  logic                accept;
  logic                final_fall;
  logic                burst_cont;

  assign tick       = (div_cnt_reg == 8'd0);
  assign accept     = sys.tx_valid && tx_ready;
  assign final_fall = (state_reg == SHIFT) && tick && ssck_reg && (edges_left_reg == LAST_EDGE);

`ifdef SPI_BURST_EN
  logic last_reg;

  // Remember whether the byte in flight closes the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (accept) begin
      last_reg <= sys.tx_last;
    end
  end

  assign burst_cont = !last_reg;
`else
  assign burst_cont = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; every timed phase advances when the divider reaches zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LEAD;
      LEAD:    if (tick) state_next = SHIFT;
      SHIFT:   if (final_fall) state_next = burst_cont ? WAIT : TRAIL;
      TRAIL:   if (tick) state_next = GAP;
      GAP:     if (tick) state_next = IDLE;
      WAIT:    if (accept) state_next = LEAD;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state_reg != IDLE);
`ifdef SPI_BURST_EN
    tx_ready = (state_reg == IDLE) || (state_reg == WAIT);
`else
    tx_ready = (state_reg == IDLE);
`endif
  end

  // Divider: reloads on accept and whenever it expires in a timed phase; holds in IDLE/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= 8'd0;
    end else if (accept) begin
      div_cnt_reg <= DIV_RELOAD;
    end else if (state_reg == LEAD || state_reg == SHIFT ||
                 state_reg == TRAIL || state_reg == GAP) begin
      div_cnt_reg <= tick ? DIV_RELOAD : div_cnt_reg - 8'd1;
    end
  end

  // Serial datapath. The shift register shifts on the ssck rise while capturing miso
  // into its LSB, so its MSB already holds the next outgoing bit when ssck falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg      <= '0;
      edges_left_reg <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      ssck_reg       <= 1'b0;
      mosi_reg       <= 1'b0;
      cs_reg         <= 1'b1;
    end else begin
      rx_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, WAIT: begin
          if (accept) begin
            shift_reg <= sys.tx_data;
            mosi_reg  <= sys.tx_data[DATA_W-1];
            cs_reg    <= 1'b0;
          end
        end
        LEAD: begin
          if (tick) begin
            ssck_reg       <= 1'b1;
            shift_reg      <= {shift_reg[DATA_W-2:0], miso};
            edges_left_reg <= SHIFT_EDGES;
          end
        end
        SHIFT: begin
          if (tick) begin
            ssck_reg       <= ~ssck_reg;
            edges_left_reg <= edges_left_reg - LAST_EDGE;
            if (!ssck_reg) begin
              shift_reg <= {shift_reg[DATA_W-2:0], miso};
            end else if (edges_left_reg == LAST_EDGE) begin
              rx_data_reg  <= shift_reg;
              rx_valid_reg <= 1'b1;
            end else begin
              mosi_reg <= shift_reg[DATA_W-1];
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            cs_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sys.tx_ready = tx_ready;
  assign sys.busy     = busy;
  assign sys.rx_data  = rx_data_reg;
  assign sys.rx_valid = rx_valid_reg;
  assign ssck         = ssck_reg;
  assign mosi         = mosi_reg;
  assign cs           = cs_reg;

endmodule

// File: tb/tb_spi_byte_master.sv
// Testbench for spi_byte_master: three instances (CLK_DIV = 4, 2, 255) share stimulus;
// sel routes tx_valid to one of them and picks which outputs are observed.
// Expected waveforms come from closed-form frame timing computed per cycle.
module tb_spi_byte_master;

`ifdef SPI_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       miso = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [2:0] cs_w, ssck_w, mosi_w, rdy_w, rxv_w, busy_w;
  logic [7:0] rxd_w [3];
  logic [7:0] rxd_sel;
  logic       rdy_sel, ssck_sel;
  logic [5:0] obs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_byte_master_if #(.DATA_W(8)) if0 ();
  spi_byte_master_if #(.DATA_W(8)) if1 ();
  spi_byte_master_if #(.DATA_W(8)) if2 ();

  assign if0.tx_data = tx_data;  assign if0.tx_last = tx_last;  assign if0.tx_valid = tx_valid && (sel == 2'd0);
  assign if1.tx_data = tx_data;  assign if1.tx_last = tx_last;  assign if1.tx_valid = tx_valid && (sel == 2'd1);
  assign if2.tx_data = tx_data;  assign if2.tx_last = tx_last;  assign if2.tx_valid = tx_valid && (sel == 2'd2);

  spi_byte_master #(.CLK_DIV(4), .DATA_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .sys(if0.slave),
    .ssck(ssck_w[0]), .mosi(mosi_w[0]), .miso(miso), .cs(cs_w[0]));
  spi_byte_master #(.CLK_DIV(2), .DATA_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .sys(if1.slave),
    .ssck(ssck_w[1]), .mosi(mosi_w[1]), .miso(miso), .cs(cs_w[1]));
  spi_byte_master #(.CLK_DIV(255), .DATA_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .sys(if2.slave),
    .ssck(ssck_w[2]), .mosi(mosi_w[2]), .miso(miso), .cs(cs_w[2]));

  assign rdy_w  = {if2.tx_ready, if1.tx_ready, if0.tx_ready};
  assign rxv_w  = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
  assign busy_w = {if2.busy, if1.busy, if0.busy};
  assign rxd_w[0] = if0.rx_data;
  assign rxd_w[1] = if1.rx_data;
  assign rxd_w[2] = if2.rx_data;

  always_comb begin
    rxd_sel  = rxd_w[0];
    rdy_sel  = rdy_w[0];
    ssck_sel = ssck_w[0];
    obs      = {cs_w[0], ssck_w[0], mosi_w[0], busy_w[0], rdy_w[0], rxv_w[0]};
    case (sel)
      2'd1: begin
        rxd_sel = rxd_w[1]; rdy_sel = rdy_w[1]; ssck_sel = ssck_w[1];
        obs = {cs_w[1], ssck_w[1], mosi_w[1], busy_w[1], rdy_w[1], rxv_w[1]};
      end
      2'd2: begin
        rxd_sel = rxd_w[2]; rdy_sel = rdy_w[2]; ssck_sel = ssck_w[2];
        obs = {cs_w[2], ssck_w[2], mosi_w[2], busy_w[2], rdy_w[2], rxv_w[2]};
      end
      default: begin
      end
    endcase
  end

  function automatic int div_of(input logic [1:0] s);
    if (s == 2'd1) return 2;
    if (s == 2'd2) return 255;
    return 4;
  endfunction

  // Reference frame: cycle t after the accept edge (t=1 is the first cycle after it).
  // Returns {cs, ssck, mosi, busy, tx_ready, rx_valid}.
  function automatic logic [5:0] model(input int t, input int d, input logic [7:0] tx, input bit cont);
    logic cs_e, ssck_e, mosi_e, busy_e, rdy_e, rxv_e;
    int   t_last;
    int   bit_i;
    t_last = 1 + 16 * d;
    cs_e   = !(t < 1 + 17 * d);
    ssck_e = (t >= 1 + d && t < t_last) ? (((t - 1) / d) % 2 == 1) : 1'b0;
    bit_i  = (t < t_last) ? 7 - (t - 1) / (2 * d) : 0;
    mosi_e = tx[bit_i];
    busy_e = (t < 1 + 18 * d);
    rdy_e  = !busy_e;
    rxv_e  = (t == t_last);
    if (cont && t >= t_last) begin
      cs_e = 1'b0; busy_e = 1'b1; rdy_e = 1'b1;
    end
    return {cs_e, ssck_e, mosi_e, busy_e, rdy_e, rxv_e};
  endfunction

  // Offer one byte to instance s, then follow its frame cycle by cycle until stop_at
  // (0 = to the end of the frame: IDLE, or WAIT for a burst continuation).
  task automatic send_byte(input logic [1:0] s, input logic [7:0] data, input logic last,
                           input logic [7:0] pat, input bit keep_valid, input int stop_at,
                           output int waited, output int rises);
    int         d, tend, idx;
    bit         cont;
    logic [5:0] exp_v;
    logic       prev_ssck;
    d = div_of(s);
    cont = BURST_EN && !last;
    sel = s; tx_data = data; tx_last = last; tx_valid = 1'b1;
    waited = 0; rises = 0;
    while (!rdy_sel && waited < 20000) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (rdy_sel !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout sel=%0d tx_ready=%b required=1", s, rdy_sel);
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tend = cont ? 1 + 16 * d : 1 + 18 * d;
    if (stop_at > 0) tend = stop_at;
    prev_ssck = 1'b0;
    for (int t = 1; t <= tend; t++) begin
      if (!keep_valid) tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      idx = (t - 1) / (2 * d);
      miso = (idx < 8) ? pat[7 - idx] : 1'($urandom_range(0, 1));
      exp_v = model(t, d, data, cont);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL frame sel=%0d data=%h t=%0d got={cs,ssck,mosi,busy,rdy,rxv}=%b required=%b",
                 s, data, t, obs, exp_v);
      end
      if (exp_v[0]) begin
        total++;
        if (rxd_sel !== pat) begin
          bad++;
          $display("FAIL rx_data sel=%0d t=%0d got=%h required=%h", s, t, rxd_sel, pat);
        end
      end
      if (ssck_sel && !prev_ssck) rises++;
      prev_ssck = ssck_sel;
      if (t < tend) begin
        @(posedge clk); #1;
      end
    end
    tx_valid = keep_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cs_w, ssck_w, mosi_w, busy_w, rxv_w, rdy_w} !== 18'b111_000_000_000_000_111) begin
      bad++;
      $display("FAIL reset_outputs got=%b required=%b",
               {cs_w, ssck_w, mosi_w, busy_w, rxv_w, rdy_w}, 18'b111_000_000_000_000_111);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rxd_w[i] !== 8'h00) begin
        bad++;
        $display("FAIL reset_rx_data dut=%0d got=%h required=00", i, rxd_w[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int w, r;
    send_byte(2'd0, 8'hA5, 1'b1, 8'h3C, 1'b0, 0, w, r);
    total++;
    if (r !== 8) begin
      bad++;
      $display("FAIL single_rises got=%0d required=8", r);
    end
    $display("single: tx=a5 rx=%h", rxd_w[0]);
  endtask

  task automatic test_random;
    int w, r;
    logic [1:0] s;
    logic [7:0] d, p;
    for (int i = 0; i < 6; i++) begin
      s = 2'($urandom_range(0, 1));
      d = 8'($urandom);
      p = 8'($urandom);
      send_byte(s, d, 1'b1, p, 1'b0, 0, w, r);
      $display("random: sel=%0d tx=%h pattern=%h rx=%h", s, d, p, rxd_sel);
    end
  endtask

  task automatic test_back_to_back;
    int w, r;
    send_byte(2'd0, 8'h01, 1'b1, 8'h5A, 1'b1, 0, w, r);
    send_byte(2'd0, 8'h80, 1'b1, 8'hC3, 1'b0, 0, w, r);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL b2b_accept_cycle extra_wait=%0d required=0", w);
    end
    $display("back_to_back: second accept wait=%0d", w);
  endtask

  task automatic test_divider;
    int w, r;
    send_byte(2'd1, 8'($urandom), 1'b1, 8'($urandom), 1'b0, 0, w, r);
    total++;
    if (r !== 8) begin
      bad++;
      $display("FAIL div2_rises got=%0d required=8", r);
    end
    send_byte(2'd2, 8'($urandom), 1'b1, 8'($urandom), 1'b0, 0, w, r);
    total++;
    if (r !== 8) begin
      bad++;
      $display("FAIL div255_rises got=%0d required=8", r);
    end
    $display("divider: div255 rises=%0d", r);
  endtask

  task automatic test_reset_mid;
    int w, r;
    send_byte(2'd0, 8'($urandom), 1'b1, 8'($urandom), 1'b0, 30, w, r);
    rst_n = 1'b0;
    #1;
    total++;
    if ({cs_w[0], ssck_w[0], mosi_w[0], busy_w[0], rxv_w[0], rdy_w[0]} !== 6'b100001) begin
      bad++;
      $display("FAIL abort_outputs got={cs,ssck,mosi,busy,rxv,rdy}=%b required=100001",
               {cs_w[0], ssck_w[0], mosi_w[0], busy_w[0], rxv_w[0], rdy_w[0]});
    end
    total++;
    if (rxd_w[0] !== 8'h00) begin
      bad++;
      $display("FAIL abort_rx_data got=%h required=00", rxd_w[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      total++;
      if ({rxv_w[0], busy_w[0], cs_w[0]} !== 3'b001) begin
        bad++;
        $display("FAIL abort_quiet cycle=%0d got={rxv,busy,cs}=%b required=001",
                 i, {rxv_w[0], busy_w[0], cs_w[0]});
      end
    end
    send_byte(2'd0, 8'($urandom), 1'b1, 8'($urandom), 1'b0, 0, w, r);
    $display("reset_mid: recovery byte rx=%h", rxd_w[0]);
  endtask

  task automatic test_burst;
    int w, r;
    logic [5:0] exp_v;
    send_byte(2'd0, 8'h11, 1'b0, 8'h96, 1'b0, 0, w, r);
    // Burst: parked in WAIT with cs low. Otherwise: idle with cs high between bytes.
    exp_v = {!BURST_EN, 1'b0, 1'b1, BURST_EN, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL burst_gap cycle=%0d got={cs,ssck,mosi,busy,rdy,rxv}=%b required=%b",
                 i, obs, exp_v);
      end
    end
    send_byte(2'd0, 8'h22, 1'b1, 8'h69, 1'b0, 0, w, r);
    $display("burst: enabled=%0d second rx=%h", BURST_EN, rxd_w[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_divider();
    test_reset_mid();
    test_burst();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
